// File: rtl/rot_window_scan.sv
// Orientation-rotation ROM sequencer: walks the 2^WIN_LOG2 square window row-major,
// registers the rotated offsets and streams them out on a valid/ready interface.
module rot_window_scan #(
    parameter int unsigned WIN_LOG2 = 4,
    parameter int unsigned DW       = 5,
    parameter int unsigned NDIR     = 36,
    parameter int unsigned DIRW     = 6,
    parameter int          RANGE    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIRW-1:0]       dir_in,
    output logic                  busy,
    output logic [DIRW-1:0]       rom_dir,
    output logic [2*WIN_LOG2-1:0] rom_addr,
    input  logic [DW-1:0]         rom_x,
    input  logic [DW-1:0]         rom_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIN_LOG2-1:0]   out_row,
    output logic [WIN_LOG2-1:0]   out_col,
    output logic [DW-1:0]         out_x,
    output logic [DW-1:0]         out_y,
    output logic                  out_inrange,
    output logic                  out_last,
    output logic                  done,
    output logic [2*WIN_LOG2:0]   inrange_cnt
);

    localparam int unsigned        AW       = 2 * WIN_LOG2;
    localparam logic [AW-1:0]      ADDR_MAX = '1;
    localparam logic [DIRW-1:0]    DIR_MAX  = DIRW'(NDIR - 1);
    localparam logic signed [DW-1:0] R_LO   = DW'(-RANGE);
    localparam logic signed [DW-1:0] R_HI   = DW'(RANGE - 1);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic [DIRW-1:0]   rom_dir_q, rom_dir_d;
    logic [AW-1:0]     rom_addr_q, rom_addr_d;
    logic              out_valid_q, out_valid_d;
    logic [WIN_LOG2-1:0] out_row_q, out_row_d;
    logic [WIN_LOG2-1:0] out_col_q, out_col_d;
    logic [DW-1:0]     out_x_q, out_x_d;
    logic [DW-1:0]     out_y_q, out_y_d;
    logic              out_inrange_q, out_inrange_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;
    logic [AW:0]       inrange_cnt_q, inrange_cnt_d;

    logic accept;
    logic load;
    logic rom_inrange;

    always_comb begin
        accept      = out_valid_q && out_ready;
        load        = !out_valid_q || out_ready;
        rom_inrange = ($signed(rom_x) >= R_LO) && ($signed(rom_x) <= R_HI) &&
                      ($signed(rom_y) >= R_LO) && ($signed(rom_y) <= R_HI);

        state_d       = state_q;
        rom_dir_d     = rom_dir_q;
        rom_addr_d    = rom_addr_q;
        out_valid_d   = out_valid_q;
        out_row_d     = out_row_q;
        out_col_d     = out_col_q;
        out_x_d       = out_x_q;
        out_y_d       = out_y_q;
        out_inrange_d = out_inrange_q;
        out_last_d    = out_last_q;
        inrange_cnt_d = inrange_cnt_q;

        // out_valid is only ever set in SCAN/FLUSH, so counting here covers both
        if (accept && out_inrange_q) begin
            inrange_cnt_d = inrange_cnt_q + (AW + 1)'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rom_dir_d     = (dir_in > DIR_MAX) ? DIR_MAX : dir_in;
                    rom_addr_d    = '0;
                    inrange_cnt_d = '0;
                    state_d       = SCAN;
                end
            end
            SCAN: begin
                if (load) begin
                    out_x_d       = rom_x;
                    out_y_d       = rom_y;
                    out_row_d     = rom_addr_q[AW-1:WIN_LOG2];
                    out_col_d     = rom_addr_q[WIN_LOG2-1:0];
                    out_last_d    = (rom_addr_q == ADDR_MAX);
                    out_inrange_d = rom_inrange;
                    out_valid_d   = 1'b1;
                    if (rom_addr_q == ADDR_MAX) begin
                        state_d = FLUSH;
                    end else begin
                        rom_addr_d = rom_addr_q + AW'(1);
                    end
                end
            end
            FLUSH: begin
                if (accept) begin
                    out_valid_d = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            rom_dir_q     <= '0;
            rom_addr_q    <= '0;
            out_valid_q   <= 1'b0;
            out_row_q     <= '0;
            out_col_q     <= '0;
            out_x_q       <= '0;
            out_y_q       <= '0;
            out_inrange_q <= 1'b0;
            out_last_q    <= 1'b0;
            done_q        <= 1'b0;
            inrange_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            rom_dir_q     <= rom_dir_d;
            rom_addr_q    <= rom_addr_d;
            out_valid_q   <= out_valid_d;
            out_row_q     <= out_row_d;
            out_col_q     <= out_col_d;
            out_x_q       <= out_x_d;
            out_y_q       <= out_y_d;
            out_inrange_q <= out_inrange_d;
            out_last_q    <= out_last_d;
            done_q        <= done_d;
            inrange_cnt_q <= inrange_cnt_d;
        end
    end

    assign busy        = busy_q;
    assign rom_dir     = rom_dir_q;
    assign rom_addr    = rom_addr_q;
    assign out_valid   = out_valid_q;
    assign out_row     = out_row_q;
    assign out_col     = out_col_q;
    assign out_x       = out_x_q;
    assign out_y       = out_y_q;
    assign out_inrange = out_inrange_q;
    assign out_last    = out_last_q;
    assign done        = done_q;
    assign inrange_cnt = inrange_cnt_q;

endmodule

// File: tb/tb_rot_window_scan.sv
// Bench for rot_window_scan: ROM model x = col-8, y = row-8; a second instance runs
// in lockstep with RANGE=4. Beats are compared against a window-walk reference.
module tb_rot_window_scan;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
        logic [4:0] x;
        logic [4:0] y;
        logic       inr;
        logic       last;
    } beat_t;

    int n_pass = 0;
    int n_total = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] dir_in;
    logic       out_ready;

    logic       busy, out_valid, out_inrange, out_last, done;
    logic [5:0] rom_dir;
    logic [7:0] rom_addr;
    logic [4:0] rom_x, rom_y, out_x, out_y;
    logic [3:0] out_row, out_col;
    logic [8:0] inrange_cnt;

    logic       d2_busy, d2_out_valid, d2_out_inrange, d2_out_last, d2_done;
    logic [5:0] d2_rom_dir;
    logic [7:0] d2_rom_addr;
    logic [4:0] d2_rom_x, d2_rom_y, d2_out_x, d2_out_y;
    logic [3:0] d2_out_row, d2_out_col;
    logic [8:0] d2_inrange_cnt;

    always #5 clk = ~clk;

    assign rom_x    = 5'(int'(rom_addr[3:0]) - 8);
    assign rom_y    = 5'(int'(rom_addr[7:4]) - 8);
    assign d2_rom_x = 5'(int'(d2_rom_addr[3:0]) - 8);
    assign d2_rom_y = 5'(int'(d2_rom_addr[7:4]) - 8);

    rot_window_scan dut (
        .clk(clk), .rst(rst), .start(start), .dir_in(dir_in), .busy(busy),
        .rom_dir(rom_dir), .rom_addr(rom_addr), .rom_x(rom_x), .rom_y(rom_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_col(out_col), .out_x(out_x), .out_y(out_y), .out_inrange(out_inrange),
        .out_last(out_last), .done(done), .inrange_cnt(inrange_cnt)
    );

    rot_window_scan #(.RANGE(4)) dut_r4 (
        .clk(clk), .rst(rst), .start(start), .dir_in(dir_in), .busy(d2_busy),
        .rom_dir(d2_rom_dir), .rom_addr(d2_rom_addr), .rom_x(d2_rom_x), .rom_y(d2_rom_y),
        .out_valid(d2_out_valid), .out_ready(out_ready), .out_row(d2_out_row),
        .out_col(d2_out_col), .out_x(d2_out_x), .out_y(d2_out_y),
        .out_inrange(d2_out_inrange), .out_last(d2_out_last), .done(d2_done),
        .inrange_cnt(d2_inrange_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    function automatic beat_t model_beat(input int i, input int rng);
        beat_t b;
        int r, c, x, y;
        r = i / 16;
        c = i % 16;
        x = c - 8;
        y = r - 8;
        b.row  = 4'(r);
        b.col  = 4'(c);
        b.x    = 5'(x);
        b.y    = 5'(y);
        b.inr  = (x >= -rng) && (x <= rng - 1) && (y >= -rng) && (y <= rng - 1);
        b.last = (i == 255);
        return b;
    endfunction

    function automatic int model_count(input int rng);
        beat_t b;
        int n = 0;
        for (int i = 0; i < 256; i++) begin
            b = model_beat(i, rng);
            if (b.inr) n++;
        end
        return n;
    endfunction

    function automatic beat_t dut_beat();
        return {out_row, out_col, out_x, out_y, out_inrange, out_last};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 32'({busy, rom_dir, rom_addr, done, inrange_cnt}), 32'(0));
        check({tag, "_data"}, 32'({out_valid, out_row, out_col, out_x, out_y,
                                   out_inrange, out_last}), 32'(0));
    endtask

    // mode 0: ready tied high, 1: random ready, 2: 20-cycle stall at beat 10,
    // 3: start pulse mid-scan, 4: reset at beat 100
    task automatic run_scan(input int mode, input logic [5:0] dir, input logic [5:0] exp_dir);
        beat_t got[$];
        beat_t cur, hold_b, mb;
        bit    stalled = 0, done_seen = 0, aborted = 0, pulsed = 0;
        int    k = 1, first_k = 0, done_k = 0, stall_cnt = 0, exp_n;
        @(negedge clk);
        dir_in = dir; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'(1));
        check("rom_dir_latched", 32'(rom_dir), 32'(exp_dir));
        while (k < 3000) begin
            if (k > 1) @(negedge clk);
            start = 1'b0;
            cur = dut_beat();
            if (stalled) check("hold_while_stalled", 32'(cur), 32'(hold_b));
            if (done) begin
                done_seen = 1;
                done_k = k;
                break;
            end
            if (out_valid && first_k == 0) first_k = k;
            case (mode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (out_valid && got.size() == 10 && stall_cnt < 20) begin
                        out_ready = 1'b0;
                        stall_cnt++;
                        if (stall_cnt == 20) begin
                            check("stall_rom_addr", 32'(rom_addr), 32'(11));
                            check("stall_row", 32'(out_row), 32'(0));
                            check("stall_col", 32'(out_col), 32'(10));
                        end
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                3: if (out_valid && got.size() == 50 && !pulsed) begin
                    start = 1'b1; dir_in = 6'd5; pulsed = 1;
                end
                4: if (out_valid && got.size() == 100) begin
                    #2 rst = 1'b1;
                    #1 check_all_zero("async_reset");
                    @(negedge clk);
                    check_all_zero("reset_held");
                    rst = 1'b0;
                    repeat (5) begin
                        @(negedge clk);
                        check("no_done_after_abort", 32'(done), 32'(0));
                        check("idle_after_abort", 32'(busy), 32'(0));
                    end
                    aborted = 1;
                    break;
                end
                default: out_ready = 1'b1;
            endcase
            if (mode == 0 && got.size() == 0 && out_valid) begin
                mb = model_beat(0, 4);
                check("r4_beat0_inrange", 32'(d2_out_inrange), 32'(mb.inr));
            end
            if (out_valid && out_ready) got.push_back(cur);
            stalled = out_valid && !out_ready;
            hold_b = cur;
            k++;
        end
        if (!aborted) check("done_seen", 32'(done_seen), 32'(1));
        exp_n = aborted ? 100 : 256;
        check("beat_count", 32'(got.size()), 32'(exp_n));
        for (int i = 0; i < got.size() && i < 256; i++)
            check($sformatf("beat%0d", i), 32'(got[i]), 32'(model_beat(i, 8)));
        if (!aborted) begin
            check("inrange_cnt", 32'(inrange_cnt), 32'(model_count(8)));
            check("r4_inrange_cnt", 32'(d2_inrange_cnt), 32'(model_count(4)));
            check("rom_dir_final", 32'(rom_dir), 32'(exp_dir));
            check("rom_addr_held", 32'(rom_addr), 32'(255));
            if (mode == 0) begin
                check("first_beat_latency", 32'(first_k), 32'(2));
                check("done_latency", 32'(done_k), 32'(258));
            end
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'(0));
            check("busy_cleared", 32'(busy), 32'(0));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dir_in = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;
        run_scan(0, 6'd31, 6'd31);
        run_scan(1, 6'd31, 6'd31);
        run_scan(2, 6'd31, 6'd31);
        run_scan(3, 6'd31, 6'd31);
        run_scan(4, 6'd31, 6'd31);
        run_scan(0, 6'd40, 6'd35);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rot_window_scan.md
Name: rot_window_scan

Overview:
- Sequencer for the orientation-rotation distributed ROMs in the SIFT descriptor stage.
- On start, it latches a dominant-orientation index and walks the 16x16 sample window in row-major order. It drives the ROM bank select and address, and registers the two combinational ROM outputs (rotated x and y offsets).
- It emits one rotated sample per beat on a valid/ready stream to the descriptor histogram accumulator. At the end it reports how many samples fell inside the descriptor area.

Parameters:
- WIN_LOG2, 4, log2 of window side; window is 2^WIN_LOG2 square, so ROM address width is 2*WIN_LOG2 = 8.
- DW, 5, width of each signed two's-complement ROM output (rotated offset).
- NDIR, 36, number of orientation bins, which is also the number of ROM banks.
- DIRW, 6, width of the orientation index (ceil(log2(NDIR))).
- RANGE, 8, in-range bound: sample valid iff -RANGE <= x <= RANGE-1 and the same for y.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle request; accepted only when busy=0.
- dir_in  in  DIRW  orientation index, sampled with an accepted start.
- busy  out  1  high from the cycle after start acceptance until the done pulse, inclusive.
- rom_dir  out  DIRW  ROM bank select (latched dir).
- rom_addr  out  2*WIN_LOG2  ROM address {row, col}.
- rom_x  in  DW  rotated x offset from the selected bank, combinational from rom_addr.
- rom_y  in  DW  rotated y offset from the selected bank, combinational from rom_addr.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_row  out  WIN_LOG2  window row of the beat.
- out_col  out  WIN_LOG2  window column of the beat.
- out_x  out  DW  registered rom_x.
- out_y  out  DW  registered rom_y.
- out_inrange  out  1  both offsets inside [-RANGE, RANGE-1].
- out_last  out  1  beat for address 2^(2*WIN_LOG2)-1.
- done  out  1  one-cycle pulse after the last beat is accepted.
- inrange_cnt  out  2*WIN_LOG2+1  number of in-range beats accepted; held after done until the next start.

Behaviour:
- Reset values: all registered outputs are 0, including busy, rom_dir, rom_addr, out_valid, out_* fields, done and inrange_cnt. State is IDLE. Reset mid-scan aborts immediately and no done is generated.
- States: IDLE, SCAN, FLUSH, DONE.
- IDLE:
  - On start=1, latch rom_dir<=dir_in, set rom_addr<=0 and inrange_cnt<=0, go to SCAN.
  - dir_in >= NDIR is clamped to NDIR-1.
- SCAN: define load = !out_valid || out_ready.
  - When load is true, the out registers capture rom_x, rom_y, row/col = rom_addr, out_last = (rom_addr == max), and out_inrange. Then out_valid<=1.
  - On the same edge, if rom_addr==max go to FLUSH (address held); otherwise rom_addr increments.
  - When load is false, everything holds. The address never advances without a capture.
  - Data must not change while out_valid=1 and out_ready=0.
- FLUSH:
  - Hold until out_valid && out_ready, then set out_valid<=0 and go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0 in the following cycle, return to IDLE.
  - start during DONE is ignored.
- inrange_cnt increments on every accepted beat (out_valid && out_ready) with out_inrange=1. It covers FLUSH as well as SCAN. Maximum value is 256, so it never wraps.
- out_inrange is computed with signed compares on DW-bit values.
- start while busy is ignored, with no relatch of dir.
- Latency: the first beat is valid 2 cycles after the start edge (cycle 1 sets up the address, cycle 2 captures).
- Throughput: 1 beat/cycle with continuous ready. A full scan is 256 beats, and done is asserted 258+ cycles after start.
- rom_addr wrap: after max, the address does not return to 0 until the next start.

Test Plan:
- Bench ROM model x = col-8, y = row-8; start with dir_in=31 and out_ready tied 1:
  - rom_dir=31.
  - Beat 0 is row 0, col 0, x=-8, y=-8, inrange=1.
  - Beat 255 has x=7, y=7 and out_last=1.
  - 256 consecutive beats.
  - done one cycle after beat 255.
  - inrange_cnt=256.
- Same model with RANGE=4: inrange_cnt=64; beat (row 0, col 0) has inrange=0.
- Random out_ready with about 50% duty:
  - Beat sequence identical to the continuous case.
  - No beat is lost or duplicated.
  - out_* are stable while valid && !ready.
- out_ready held 0 for 20 cycles at beat 10:
  - rom_addr stays at 11.
  - out_row=0, out_col=10 held.
  - Resumes with col 11.
- start pulsed during SCAN with dir_in=5:
  - rom_dir stays 31.
  - The scan completes normally.
  - dir_in=40 in IDLE latches 35.
- rst asserted at beat 100:
  - All outputs are 0 asynchronously and no done pulse.
  - A new start after release begins at row 0, col 0.
